// File: rtl/compound_dispatch_pkg.sv
// ============================================================================
//  Module  : compound_dispatch_types (package)
//  Purpose : Shared types for compound_dispatch. Holds the access mode,
//            the FSM section encoding, the CompoundType payload, the reset
//            word and the mode-dependent word transform.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package compound_dispatch_types;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mode_t;

  typedef enum logic {
    SECTION_A = 1'b0,
    SECTION_B = 1'b1
  } Sections;

  typedef struct packed {
    mode_t              mode;
    logic signed [31:0] x;
    logic               y;
  } CompoundType;

  localparam CompoundType RESET_WORD = '{mode: READ, x: 32'sd0, y: 1'b0};

  // READ words pass through untouched. WRITE words get x += inc, which wraps
  // modulo 2^32, and y inverted.
  function automatic CompoundType xform(input CompoundType w,
                                        input logic signed [31:0] inc);
    CompoundType r;
    r = w;
    if (w.mode == WRITE) begin
      r.x = w.x + inc;
      r.y = ~w.y;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/compound_dispatch_timer.sv
// ============================================================================
//  Module  : compound_dispatch_timer
//  Purpose : Offer timeout counter. Counts cycles while 'en' is high. It
//            pulses 'expire' in the cycle the count reaches TIMEOUT_CYC and
//            restarts from zero on that pulse. 'clr' forces the count to zero.
//  Ports   : clk, rst (async, active-high)
//            clr     in  1  clear count (priority over en)
//            en      in  1  count this cycle
//            expire  out 1  combinational expiry pulse
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module compound_dispatch_timer #(
  parameter  int TIMEOUT_CYC = 8,
  localparam int TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    // The pulse is raised on the last counting cycle, so the owner acts on
    // the same edge on which the count would reach TIMEOUT_CYC.
    expire = en && !clr && (cnt_q == TW'(TIMEOUT_CYC - 1));
    cnt_d  = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/compound_dispatch.sv
// ============================================================================
//  Module  : compound_dispatch
//  Purpose : Samples a CompoundType from m_in, transforms it by mode and
//            offers it on one of NUM_CH blocking outputs, which are chosen
//            round-robin, using a notify/sync handshake. The FSM has two
//            sections: SECTION_A samples the input and SECTION_B offers the
//            word.
//  Ports   : clk, rst (async, active-high)
//            m_in          in   CompoundType           master input
//            b_out         out  CompoundType[NUM_CH]   per-channel data
//            b_out_sync    in   NUM_CH                 consumer ready
//            b_out_notify  out  NUM_CH                 one-hot/zero offer
//            ch_sel        out  $clog2(NUM_CH)         current/last channel
//            xfer_cnt      out  CNT_W                  saturating xfer count
//  Config  : `define COMPOUND_DISPATCH_TIMEOUT_EN to move an unanswered
//            offer to the next channel after TIMEOUT_CYC cycles.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module compound_dispatch
  import compound_dispatch_types::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int INC         = 1,
  parameter  int CNT_W       = 16,
  parameter  int TIMEOUT_CYC = 8,
  localparam int SEL_W       = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  CompoundType              m_in,
  output CompoundType [NUM_CH-1:0] b_out,
  input  logic        [NUM_CH-1:0] b_out_sync,
  output logic        [NUM_CH-1:0] b_out_notify,
  output logic        [SEL_W-1:0]  ch_sel,
  output logic        [CNT_W-1:0]  xfer_cnt
);

  Sections                  section_q, section_d;
  CompoundType              compound_q, compound_d;
  CompoundType [NUM_CH-1:0] b_out_q, b_out_d;
  logic        [NUM_CH-1:0] notify_q, notify_d;
  logic        [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic        [SEL_W-1:0]  ch_sel_q, ch_sel_d;
  logic        [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic                     take;
  logic                     timer_expire;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Explicit wrap, so NUM_CH does not have to be a power of two.
  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Sync counts only on the channel being offered, and only during an offer.
  assign take = (section_q == SECTION_B) && notify_q[ch_sel_q] && b_out_sync[ch_sel_q];

`ifdef COMPOUND_DISPATCH_TIMEOUT_EN
  compound_dispatch_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (section_q != SECTION_B || take),
    .en     (section_q == SECTION_B && !take),
    .expire (timer_expire)
  );
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timer_expire = 1'b0;
`endif

  always_comb begin
    section_d  = section_q;
    compound_d = compound_q;
    b_out_d    = b_out_q;
    notify_d   = notify_q;
    rr_ptr_d   = rr_ptr_q;
    ch_sel_d   = ch_sel_q;
    xfer_cnt_d = xfer_cnt_q;

    case (section_q)
      SECTION_A: begin
        compound_d        = xform(m_in, INC);
        ch_sel_d          = rr_ptr_q;
        b_out_d[rr_ptr_q] = xform(m_in, INC);
        notify_d          = onehot(rr_ptr_q);
        section_d         = SECTION_B;
      end
      SECTION_B: begin
        // compound_q always holds the word in flight. The offered entry is
        // pinned to it, and a timeout carries it to the next channel.
        b_out_d[ch_sel_q] = compound_q;
        if (take) begin
          notify_d  = '0;
          rr_ptr_d  = next_ch(ch_sel_q);
          section_d = SECTION_A;
          if (xfer_cnt_q != {CNT_W{1'b1}}) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
          end
        end else if (timer_expire) begin
          ch_sel_d                   = next_ch(ch_sel_q);
          b_out_d[next_ch(ch_sel_q)] = compound_q;
          notify_d                   = onehot(next_ch(ch_sel_q));
        end
      end
      default: section_d = SECTION_B;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Reset comes up already offering the reset word on channel 0.
      section_q  <= SECTION_B;
      compound_q <= RESET_WORD;
      b_out_q    <= {NUM_CH{RESET_WORD}};
      notify_q   <= NUM_CH'(1);
      rr_ptr_q   <= '0;
      ch_sel_q   <= '0;
      xfer_cnt_q <= '0;
    end else begin
      section_q  <= section_d;
      compound_q <= compound_d;
      b_out_q    <= b_out_d;
      notify_q   <= notify_d;
      rr_ptr_q   <= rr_ptr_d;
      ch_sel_q   <= ch_sel_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign b_out        = b_out_q;
  assign b_out_notify = notify_q;
  assign ch_sel       = ch_sel_q;
  assign xfer_cnt     = xfer_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_compound_dispatch.sv
// ============================================================================
//  Module  : tb_compound_dispatch
//  Purpose : Self-checking bench for compound_dispatch with a
//            transaction-level reference model.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_compound_dispatch;
  import compound_dispatch_types::*;

  localparam int NUM_CH      = 4;
  localparam int INC         = 1;
  localparam int CNT_W       = 4;   // small, so saturation is reachable
  localparam int TIMEOUT_CYC = 8;
  localparam int SEL_W       = $clog2(NUM_CH);
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  CompoundType              m_in;
  CompoundType [NUM_CH-1:0] b_out;
  logic        [NUM_CH-1:0] b_out_sync;
  logic        [NUM_CH-1:0] b_out_notify;
  logic        [SEL_W-1:0]  ch_sel;
  logic        [CNT_W-1:0]  xfer_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the offered channel, the transfer count and the
  // expected contents of every output entry.
  int          m_ch;
  int          m_cnt;
  CompoundType m_bout [NUM_CH];

  compound_dispatch #(
    .NUM_CH(NUM_CH), .INC(INC), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .m_in(m_in), .b_out(b_out), .b_out_sync(b_out_sync),
    .b_out_notify(b_out_notify), .ch_sel(ch_sel), .xfer_cnt(xfer_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CH-1:0] oh(input int c);
    return NUM_CH'(1) << c;
  endfunction

  function automatic CompoundType spec_word(input CompoundType w);
    CompoundType r;
    logic [31:0] sum;
    r = w;
    if (w.mode == WRITE) begin
      sum = w.x + INC;
      r.x = sum;
      r.y = !w.y;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_ch  = 0;
    m_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) m_bout[i] = RESET_WORD;
  endfunction

  task automatic test_reset();
    int hold;
    rst = 1'b1; m_in = RESET_WORD; b_out_sync = '0;
    model_reset();
    repeat (2) step();
    n_vec++;
    if (b_out_notify !== 4'b0001 || b_out[0] !== RESET_WORD || xfer_cnt !== '0 || ch_sel !== '0) begin
      n_err++;
      $display("FAIL reset_state: notify=%b b_out0=%h cnt=%0d sel=%0d, want 0001 %h 0 0",
               b_out_notify, b_out[0], xfer_cnt, ch_sel, RESET_WORD);
    end
    rst = 1'b0;
`ifdef COMPOUND_DISPATCH_TIMEOUT_EN
    hold = 5;
`else
    hold = 20;
`endif
    for (int c = 0; c < hold; c++) begin
      step();
      n_vec++;
      if (b_out_notify !== 4'b0001 || b_out[0] !== RESET_WORD || xfer_cnt !== '0) begin
        n_err++;
        $display("FAIL reset_hold c=%0d: notify=%b b_out0=%h cnt=%0d, want 0001 %h 0",
                 c, b_out_notify, b_out[0], xfer_cnt, RESET_WORD);
      end
    end
  endtask

  task automatic test_directed_write();
    CompoundType exp;
    b_out_sync = 4'b0001;
    step();
    b_out_sync = '0;
    n_vec++;
    if (b_out_notify !== 4'b0000 || xfer_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL first_xfer: notify=%b cnt=%0d, want 0000 1", b_out_notify, xfer_cnt);
    end
    m_in = '{mode: WRITE, x: 32'sd5, y: 1'b0};
    step();
    exp = '{mode: WRITE, x: 32'sd6, y: 1'b1};
    n_vec++;
    if (b_out_notify !== 4'b0010 || b_out[1] !== exp || ch_sel !== 2'd1 ||
        b_out[0] !== RESET_WORD || xfer_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL write_xform: notify=%b b1=%h sel=%0d b0=%h cnt=%0d, want 0010 %h 1 %h 1",
               b_out_notify, b_out[1], ch_sel, b_out[0], xfer_cnt, exp, RESET_WORD);
    end
    m_ch = 1; m_cnt = 1; m_bout[1] = exp;
  endtask

  task automatic test_x_wrap();
    CompoundType exp;
    b_out_sync = 4'b0010;
    step();
    b_out_sync = '0;
    m_in = '{mode: WRITE, x: 32'sh7FFFFFFF, y: 1'b1};
    step();
    exp = '{mode: WRITE, x: 32'sh80000000, y: 1'b0};
    n_vec++;
    if (b_out_notify !== 4'b0100 || b_out[2] !== exp || xfer_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL x_wrap: notify=%b b2=%h cnt=%0d, want 0100 %h 2",
               b_out_notify, b_out[2], xfer_cnt, exp);
    end
    m_ch = 2; m_cnt = 2; m_bout[2] = exp;
  endtask

  // Moves n words through the model. While a word waits for its consumer,
  // sync is driven at random on the other channels only. Those cycles
  // must not complete a transfer.
  task automatic run_words(input int n, input int max_dly, input bit all_sync);
    CompoundType w;
    int d;
    for (int k = 0; k < n; k++) begin
      d = (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
      for (int c = 0; c <= d; c++) begin
        n_vec++;
        if (b_out_notify !== oh(m_ch) || ch_sel !== SEL_W'(m_ch) || xfer_cnt !== CNT_W'(m_cnt)) begin
          n_err++;
          $display("FAIL offer k=%0d c=%0d: notify=%b sel=%0d cnt=%0d, want %b %0d %0d",
                   k, c, b_out_notify, ch_sel, xfer_cnt, oh(m_ch), m_ch, m_cnt);
        end
        for (int i = 0; i < NUM_CH; i++) begin
          n_vec++;
          if (b_out[i] !== m_bout[i]) begin
            n_err++;
            $display("FAIL b_out[%0d] k=%0d: got %h want %h", i, k, b_out[i], m_bout[i]);
          end
        end
        if (all_sync) b_out_sync = '1;
        else if (c < d) b_out_sync = NUM_CH'($urandom) & ~oh(m_ch);
        else b_out_sync = NUM_CH'($urandom) | oh(m_ch);
        step();
      end
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      m_ch  = (m_ch + 1) % NUM_CH;
      n_vec++;
      if (b_out_notify !== '0 || xfer_cnt !== CNT_W'(m_cnt)) begin
        n_err++;
        $display("FAIL after_xfer k=%0d: notify=%b cnt=%0d, want 0 %0d", k, b_out_notify, xfer_cnt, m_cnt);
      end
      w.mode = mode_t'($urandom_range(1, 0));
      w.x    = $urandom;
      w.y    = 1'($urandom_range(1, 0));
      m_in   = w;
      b_out_sync = all_sync ? '1 : NUM_CH'($urandom);
      step();
      m_bout[m_ch] = spec_word(w);
    end
    b_out_sync = '0;
  endtask

  task automatic test_back_to_back();
    run_words(8, 0, 1'b1);
  endtask

  task automatic test_random();
    run_words(24, 3, 1'b0);
  endtask

  task automatic test_reset_mid_offer();
    for (int i = 0; i < NUM_CH && m_ch != 2; i++) run_words(1, 1, 1'b0);
    b_out_sync = '0;
    step();
    n_vec++;
    if (b_out_notify !== 4'b0100) begin
      n_err++;
      $display("FAIL pre_reset: notify=%b, want 0100", b_out_notify);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (b_out_notify !== 4'b0001 || xfer_cnt !== '0 || ch_sel !== '0 || b_out[2] !== RESET_WORD) begin
      n_err++;
      $display("FAIL async_reset: notify=%b cnt=%0d sel=%0d b2=%h, want 0001 0 0 %h",
               b_out_notify, xfer_cnt, ch_sel, b_out[2], RESET_WORD);
    end
    model_reset();
    step();
    rst = 1'b0;
    run_words(4, 2, 1'b0);
  endtask

`ifdef COMPOUND_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    b_out_sync = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    for (int hop = 1; hop <= 2; hop++) begin
      for (int c = 1; c <= TIMEOUT_CYC; c++) begin
        step();
        if (c == TIMEOUT_CYC) m_ch = hop;
        n_vec++;
        if (b_out_notify !== oh(m_ch) || ch_sel !== SEL_W'(m_ch) ||
            b_out[m_ch] !== RESET_WORD || xfer_cnt !== '0) begin
          n_err++;
          $display("FAIL timeout hop=%0d c=%0d: notify=%b sel=%0d cnt=%0d, want %b %0d 0",
                   hop, c, b_out_notify, ch_sel, xfer_cnt, oh(m_ch), m_ch);
        end
      end
    end
    run_words(3, 2, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed_write();
    test_x_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid_offer();
`ifdef COMPOUND_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
